// File: rtl/delay_line_capture.sv
`default_nettype none
// ============================================================================
// Module   : delay_line_capture
// Brief    : Fires a launch pulse into a tapped delay line on a UART RX falling
//            edge, snapshots the taps and offers them over valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module delay_line_capture #(
    parameter int P_LENGTH = 16,
    parameter int P_SETTLE = 4,
    parameter int P_CW     = $clog2(P_LENGTH + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_trig,
    output logic                o_launch,
    input  logic [P_LENGTH-1:0] i_taps,
    output logic [P_LENGTH-1:0] o_data,
    output logic [P_CW-1:0]     o_count,
    output logic                o_bubble,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_overrun
);

    localparam int                 c_ctr_w    = $clog2(P_SETTLE + 1);
    localparam logic [c_ctr_w-1:0] c_ctr_last = c_ctr_w'(P_SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_CAPTURE = 3'd2,
        S_HOLD    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_ctr_w-1:0]  r_ctr;
    logic                r_sync1;
    logic                r_sync2;
    logic [P_LENGTH-1:0] r_cap;
    logic [P_LENGTH-1:0] r_data;
    logic [P_CW-1:0]     r_count;
    logic                r_bubble;
    logic                r_valid;
    logic                r_overrun;

    logic                w_edge;
    logic [P_CW-1:0]     w_popcount;
    logic                w_bubble;

    // Sync flops idle high so a released reset never looks like a falling edge.
    assign w_edge = r_sync2 & ~r_sync1;

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < P_LENGTH; i++) begin
            w_popcount = w_popcount + P_CW'(r_cap[i]);
        end
    end

    // A clean thermometer 0..01..1 plus one is a power of two, sharing no set bits.
    assign w_bubble = |(r_cap & (r_cap + P_LENGTH'(1)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ctr     <= '0;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_cap     <= '0;
            r_data    <= '0;
            r_count   <= '0;
            r_bubble  <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sync1 <= i_trig;
            r_sync2 <= r_sync1;

            if (w_edge && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        r_state <= S_LAUNCH;
                        r_ctr   <= '0;
                    end
                end
                S_LAUNCH: begin
                    r_ctr <= r_ctr + 1'b1;
                    if (r_ctr == c_ctr_last) begin
                        r_cap   <= i_taps;
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_data   <= r_cap;
                    r_count  <= w_popcount;
                    r_bubble <= w_bubble;
                    r_valid  <= 1'b1;
                    r_state  <= S_HOLD;
                end
                S_HOLD: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ctr   <= '0;
                        r_state <= S_RECOVER;
                    end
                end
                S_RECOVER: begin
                    r_ctr <= r_ctr + 1'b1;
                    if (r_ctr == c_ctr_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Decoded straight from state so it drops the instant reset asserts.
    assign o_launch  = (r_state == S_LAUNCH);
    assign o_data    = r_data;
    assign o_count   = r_count;
    assign o_bubble  = r_bubble;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_delay_line_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_line_capture
// Brief    : Self-checking bench for delay_line_capture against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_delay_line_capture;

    localparam int L  = 16;
    localparam int P  = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          trig;
    logic          launch;
    logic [L-1:0]  taps;
    logic [L-1:0]  data;
    logic [CW-1:0] count;
    logic          bubble;
    logic          valid;
    logic          ready;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delay_line_capture #(
        .P_LENGTH (L),
        .P_SETTLE (P),
        .P_CW     (CW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_trig    (trig),
        .o_launch  (launch),
        .i_taps    (taps),
        .o_data    (data),
        .o_count   (count),
        .o_bubble  (bubble),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_overrun (overrun)
    );

    function automatic int ref_count(input logic [L-1:0] v);
        int n = 0;
        for (int i = 0; i < L; i++) if (v[i]) n++;
        return n;
    endfunction

    // Clean means no one appears above the first zero when scanning from bit 0.
    function automatic logic ref_bubble(input logic [L-1:0] v);
        logic seen_zero = 1'b0;
        logic bad       = 1'b0;
        for (int i = 0; i < L; i++) begin
            if (!v[i]) seen_zero = 1'b1;
            else if (seen_zero) bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_snapshot(input string tag, input logic [L-1:0] exp);
        chk({tag, "_valid"},  32'(valid),  32'd1);
        chk({tag, "_data"},   32'(data),   32'(exp));
        chk({tag, "_count"},  32'(count),  32'(ref_count(exp)));
        chk({tag, "_bubble"}, 32'(bubble), 32'(ref_bubble(exp)));
    endtask

    // Trigger, check launch width, then land in the first cycle with valid high.
    task automatic capture(input logic [L-1:0] v, input bit dbl);
        taps = v;
        trig = 1'b0;
        tick;
        chk("launch_at_T", 32'(launch), 32'd0);
        tick;
        trig = 1'b1;
        for (int i = 1; i <= P; i++) begin
            chk($sformatf("launch_T+%0d", i), 32'(launch), 32'd1);
            if (dbl && i == 2) trig = 1'b0;
            if (dbl && i == 3) trig = 1'b1;
            tick;
        end
        taps = L'($urandom);
        chk("launch_after", 32'(launch), 32'd0);
        chk("valid_early",  32'(valid),  32'd0);
        tick;
        check_snapshot("snap", v);
    endtask

    task automatic hold_release(input int n_wait, input logic [L-1:0] v);
        for (int i = 0; i < n_wait; i++) begin
            taps = L'($urandom);
            tick;
            check_snapshot("hold", v);
        end
        ready = 1'b1;
        tick;
        ready = 1'b0;
        chk("valid_drop", 32'(valid), 32'd0);
        for (int i = 0; i < P; i++) begin
            chk($sformatf("recover_launch%0d", i), 32'(launch), 32'd0);
            tick;
        end
        chk("valid_idle", 32'(valid), 32'd0);
    endtask

    initial begin
        logic [L-1:0] v;
        int           k;

        rst   = 1'b1;
        trig  = 1'b1;
        ready = 1'b0;
        taps  = '0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_launch",  32'(launch),  32'd0);
        chk("rst_data",    32'(data),    32'd0);
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_bubble",  32'(bubble),  32'd0);
        chk("rst_valid",   32'(valid),   32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("idle_launch", 32'(launch), 32'd0);
            chk("idle_valid",  32'(valid),  32'd0);
        end

        capture(16'h00FF, 1'b0);
        hold_release(0, 16'h00FF);
        capture(16'hFFFF, 1'b0);
        hold_release(1, 16'hFFFF);
        capture(16'h0000, 1'b0);
        hold_release(0, 16'h0000);
        capture(16'h00F7, 1'b0);
        hold_release(0, 16'h00F7);

        v = L'($urandom);
        capture(v, 1'b0);
        hold_release(10, v);
        chk("no_overrun_bp", 32'(overrun), 32'd0);

        for (int n = 0; n < 8; n++) begin
            if (n[0]) begin
                k = $urandom_range(0, L);
                v = (k == L) ? '1 : L'((32'd1 << k) - 32'd1);
            end else begin
                v = L'($urandom);
            end
            capture(v, 1'b0);
            hold_release($urandom_range(0, 3), v);
        end
        chk("no_overrun_rand", 32'(overrun), 32'd0);

        v = L'($urandom);
        capture(v, 1'b1);
        chk("overrun_set", 32'(overrun), 32'd1);
        hold_release(0, v);
        repeat (100) tick;
        chk("overrun_sticky", 32'(overrun), 32'd1);
        chk("overrun_no_capture", 32'(valid), 32'd0);

        taps = L'($urandom);
        trig = 1'b0;
        tick;
        tick;
        trig = 1'b1;
        tick;
        chk("midrst_launch_before", 32'(launch), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_launch_async", 32'(launch),  32'd0);
        chk("midrst_valid",        32'(valid),   32'd0);
        chk("midrst_overrun",      32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("postrst_valid",  32'(valid),  32'd0);
            chk("postrst_launch", 32'(launch), 32'd0);
            tick;
        end
        v = L'($urandom);
        capture(v, 1'b0);
        hold_release(2, v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
